ped_crossing_ctrl: RTL and testbench



---
 rtl/ped_pkg.sv | 16 +
 rtl/ped_crossing_ctrl_phase_timer.sv | 28 ++
 rtl/ped_crossing_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing controller.
package ped_pkg;

    // Controller state encoding
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WALK  = 3'd2,
        S_CLEAR = 3'd3,
        S_FAULT = 3'd4
    } ped_state_t;

    localparam int unsigned DEF_WALK_CYCLES  = 8;
    localparam int unsigned DEF_CLEAR_CYCLES = 6;

endpackage

// File: rtl/ped_crossing_ctrl_phase_timer.sv
// Loadable down-counter timing the WALK and CLEAR phases.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement saturates at zero so the count never wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian WALK / DON'T-WALK controller slaved to the vehicle lamp FSM.
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned WALK_CYCLES  = DEF_WALK_CYCLES,
    parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic veh_red,
    input  logic veh_green,
    input  logic veh_yellow,
    input  logic ped_button,
    output logic walk,
    output logic dont_walk,
    output logic hold_red,
    output logic req_pending,
    output logic abort,
    output logic fault
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    ped_state_t       state;
    logic             red_q;
    logic             again;
    logic             lamp_legal;
    logic             red_rise;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // Lamp legality, red edge detect and timer control for the coming edge
    always_comb begin
        lamp_legal   = ({1'b0, veh_red} + {1'b0, veh_green} + {1'b0, veh_yellow}) == 2'd1;
        red_rise     = veh_red && !red_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        if (lamp_legal) begin
            case (state)
                S_WAIT: begin
                    if (red_rise) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = WALK_LOAD;
                    end
                end
                S_WALK: begin
                    if (veh_red) begin
                        if (tmr_zero) begin
                            tmr_load     = 1'b1;
                            tmr_load_val = CLEAR_LOAD;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    tmr_dec = veh_red && !tmr_zero;
                end
                default: ;
            endcase
        end
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Crossing FSM; outputs are registered alongside the state they decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            red_q       <= 1'b1;
            again       <= 1'b0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            hold_red    <= 1'b0;
            req_pending <= 1'b0;
            abort       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            red_q <= veh_red;
            abort <= 1'b0;
            if (!lamp_legal && (state != S_FAULT)) begin
                state       <= S_FAULT;
                again       <= 1'b0;
                walk        <= 1'b0;
                dont_walk   <= 1'b1;
                hold_red    <= 1'b0;
                req_pending <= 1'b0;
                fault       <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ped_button) begin
                            state       <= S_WAIT;
                            req_pending <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (red_rise) begin
                            state       <= S_WALK;
                            walk        <= 1'b1;
                            dont_walk   <= 1'b0;
                            hold_red    <= 1'b1;
                            req_pending <= 1'b0;
                        end
                    end
                    S_WALK: begin
                        if (!veh_red) begin
                            state     <= S_IDLE;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            hold_red  <= 1'b0;
                            abort     <= 1'b1;
                        end else if (tmr_zero) begin
                            state     <= S_CLEAR;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        if (!veh_red) begin
                            state     <= S_IDLE;
                            again     <= 1'b0;
                            dont_walk <= 1'b1;
                            hold_red  <= 1'b0;
                            abort     <= 1'b1;
                        end else if (tmr_zero) begin
                            // A press on the final CLEAR cycle still queues a crossing
                            state       <= (again || ped_button) ? S_WAIT : S_IDLE;
                            req_pending <= again || ped_button;
                            again       <= 1'b0;
                            dont_walk   <= 1'b1;
                            hold_red    <= 1'b0;
                        end else begin
                            dont_walk <= !dont_walk;
                            if (ped_button) begin
                                again <= 1'b1;
                            end
                        end
                    end
                    S_FAULT: ;
                    default: begin
                        state       <= S_IDLE;
                        again       <= 1'b0;
                        walk        <= 1'b0;
                        dont_walk   <= 1'b1;
                        hold_red    <= 1'b0;
                        req_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with default 8/6 cycle phases.
module tb_ped_crossing_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic veh_red, veh_green, veh_yellow, ped_button;
    logic walk, dont_walk, hold_red, req_pending, abort, fault;
    logic [5:0] outs;

    int vecs = 0;
    int errs = 0;

    // {walk, dont_walk, hold_red, req_pending, abort, fault}
    localparam logic [5:0] O_IDLE   = 6'b010000;
    localparam logic [5:0] O_WAIT   = 6'b010100;
    localparam logic [5:0] O_WALK   = 6'b101000;
    localparam logic [5:0] O_CLR_ON = 6'b011000;
    localparam logic [5:0] O_CLR_OF = 6'b001000;
    localparam logic [5:0] O_ABORT  = 6'b010010;
    localparam logic [5:0] O_FAULT  = 6'b010001;

    assign outs = {walk, dont_walk, hold_red, req_pending, abort, fault};

    always #5 clk = ~clk;

    ped_crossing_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .veh_red     (veh_red),
        .veh_green   (veh_green),
        .veh_yellow  (veh_yellow),
        .ped_button  (ped_button),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .hold_red    (hold_red),
        .req_pending (req_pending),
        .abort       (abort),
        .fault       (fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lamps(input logic r, input logic g, input logic y);
        veh_red    = r;
        veh_green  = g;
        veh_yellow = y;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        vecs++;
        assert (outs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
    endtask

    // Button during green, then yellow, then red rising edge; ends with WALK visible
    task automatic request_and_red(input string tag);
        lamps(1'b0, 1'b1, 1'b0);
        ped_button = 1'b1;
        step();
        chk({tag, "_wait0"}, O_WAIT);
        ped_button = 1'b0;
        lamps(1'b0, 1'b0, 1'b1);
        step();
        chk({tag, "_wait1"}, O_WAIT);
        lamps(1'b1, 1'b0, 1'b0);
        step();
        chk({tag, "_walk_rise"}, O_WALK);
    endtask

    initial begin
        reset_n    = 1'b0;
        ped_button = 1'b0;
        lamps(1'b1, 1'b0, 1'b0);

        // 1: reset values and idle with red toggling
        #12;
        chk("reset", O_IDLE);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i >= 6 && i < 13) lamps(1'b0, 1'b1, 1'b0);
            else                  lamps(1'b1, 1'b0, 1'b0);
            step();
            chk("idle_toggle", O_IDLE);
        end

        // 2: full crossing
        request_and_red("t2");
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t2_walk", O_WALK);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_clear", (i % 2 == 0) ? O_CLR_ON : O_CLR_OF);
        end
        step();
        chk("t2_idle", O_IDLE);
        step();
        chk("t2_idle_hold", O_IDLE);

        // 3: red withdrawn at WALK cycle 3
        request_and_red("t3");
        step();
        chk("t3_walk2", O_WALK);
        step();
        chk("t3_walk3", O_WALK);
        lamps(1'b0, 1'b1, 1'b0);
        step();
        chk("t3_abort", O_ABORT);
        step();
        chk("t3_abort_end", O_IDLE);

        // 4: press during CLEAR cycle 2 queues another crossing
        request_and_red("t4");
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4_walk", O_WALK);
        end
        step();
        chk("t4_clear1", O_CLR_ON);
        step();
        chk("t4_clear2", O_CLR_OF);
        ped_button = 1'b1;
        step();
        chk("t4_clear3", O_CLR_ON);
        ped_button = 1'b0;
        for (int i = 3; i < 6; i++) begin
            step();
            chk("t4_clear", (i % 2 == 0) ? O_CLR_ON : O_CLR_OF);
        end
        step();
        chk("t4_requeued", O_WAIT);
        lamps(1'b0, 1'b1, 1'b0);
        step();
        chk("t4_wait_green", O_WAIT);
        lamps(1'b1, 1'b0, 1'b0);
        step();
        chk("t4_walk2_rise", O_WALK);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4_walk2", O_WALK);
        end
        step();
        chk("t4_walk2_end", O_CLR_ON);
        for (int i = 1; i < 6; i++) step();
        step();
        chk("t4_idle", O_IDLE);

        // 5: illegal lamps during WAIT lock into FAULT until reset
        lamps(1'b0, 1'b1, 1'b0);
        ped_button = 1'b1;
        step();
        chk("t5_wait", O_WAIT);
        ped_button = 1'b0;
        lamps(1'b1, 1'b1, 1'b0);
        step();
        chk("t5_fault", O_FAULT);
        lamps(1'b0, 1'b1, 1'b0);
        ped_button = 1'b1;
        step();
        chk("t5_fault_green", O_FAULT);
        lamps(1'b1, 1'b0, 1'b0);
        step();
        chk("t5_fault_red", O_FAULT);
        ped_button = 1'b0;
        lamps(1'b0, 1'b0, 1'b1);
        step();
        chk("t5_fault_yellow", O_FAULT);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_reset", O_IDLE);
        #2;
        reset_n = 1'b1;
        lamps(1'b1, 1'b0, 1'b0);
        step();
        chk("t5_after_reset", O_IDLE);

        // 6: asynchronous reset mid-WALK, then a clean crossing
        request_and_red("t6");
        step();
        step();
        chk("t6_walk3", O_WALK);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset", O_IDLE);
        #2;
        reset_n = 1'b1;
        request_and_red("t6b");
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t6_walk", O_WALK);
        end
        step();
        chk("t6_clear", O_CLR_ON);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
